// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer:
// op encodings, FSM state encoding, default multiplier latency and the
// width of the EX-to-WB hi/lo bus ({we, we, hi, lo}).
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int MUL_LAT_DEF = 2;
  localparam int HILO_W      = 66;

  // Divide ops carry op[1] = 1.
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Signed variants are the even encodings.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one MULT/MULTU/DIV/DIVU from EX through the shared
// external multiplier and iterative divider, stalls the pipeline while the
// unit works, and finishes with a single-cycle HI/LO write.
// Optional build macro: MULDIV_DIV0_FAST_EN -- a divide by zero bypasses the
// divider and returns hi = dividend, lo = all ones from the accept cycle.
//
// Handshakes:
//   EX side: req_valid is a level from EX; a request is taken in IDLE when
//   req_valid=1 and annul=0, and stallreq rises in that same cycle. stallreq
//   stays high while the op is in flight and drops in DONE, so EX retires
//   the instruction there; req_valid seen in DONE belongs to it and is
//   ignored.
//   Divider side: div_start is a level held until the cycle div_ready=1 is
//   seen; that cycle transfers div_result. div_annul is a 1-cycle abort.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        annul,
  output logic        stallreq,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] CNT_LAST = 3'(MUL_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div0_fast;

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = (req_b == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  // Next-state, operand/result capture and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stallreq  = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;
    hilo_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !annul) begin
          stallreq = 1'b1;
          sgn_d    = op_is_signed(req_op);
          a_d      = req_a;
          b_d      = req_b;
          cnt_d    = 3'd0;
          if (op_is_div(req_op)) begin
            if (div0_fast) begin
              hi_d    = req_a;
              lo_d    = 32'hFFFF_FFFF;
              state_d = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        stallreq = 1'b1;
        if (annul) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          hi_d    = mul_result[63:32];
          lo_d    = mul_result[31:0];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DIV: begin
        stallreq  = 1'b1;
        div_start = 1'b1;
        // annul beats a simultaneous div_ready: the result is dropped.
        if (annul) begin
          div_annul = 1'b1;
          state_d   = ST_IDLE;
        end else if (div_ready) begin
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        hilo_we = !annul;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset silences every strobe; the divider is reset on its own, so no
    // div_annul is sent for it.
    if (rst) begin
      stallreq  = 1'b0;
      div_start = 1'b0;
      div_annul = 1'b0;
      hilo_we   = 1'b0;
    end
  end

  // State, counter, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      sgn_q   <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mul_signed = sgn_q;
  assign div_signed = sgn_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign hi_wdata   = hi_q;
  assign lo_wdata   = lo_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: behavioural multiplier and divider models,
// directed scenarios followed by randomized operations, with a scoreboard
// of expected {hi,lo} values and per-operation timing expectations.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = MUL_LAT_DEF;
  localparam int MUL_IDX = (MUL_LAT >= 2) ? MUL_LAT - 2 : 0;

  logic        clk, rst;
  logic        req_valid, annul;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        stallreq, mul_signed, div_start, div_signed, div_annul;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic [63:0] mul_result, div_result;
  logic        div_ready, hilo_we;
  logic [31:0] hi_wdata, lo_wdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int div_dly = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .annul(annul), .stallreq(stallreq),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready), .hilo_we(hilo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .dbg_state(dbg_state)
  );

  // Reference arithmetic: {hi,lo} for a MULT/MULTU product or
  // {remainder,quotient} for DIV/DIVU; a zero divisor yields {a, all ones}.
  function automatic logic [63:0] ref_hilo(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    if (op[1] == 1'b0) begin
      if (op[0] == 1'b0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op[0] == 1'b0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Multiplier model: result valid MUL_LAT cycles after operands appear.
  logic [63:0] mul_prod;
  logic [63:0] mul_pipe [0:7];
  assign mul_prod = ref_hilo({1'b0, ~mul_signed}, mul_a, mul_b);
  always @(posedge clk) begin
    mul_pipe[0] <= mul_prod;
    for (int i = 1; i < 8; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = (MUL_LAT == 1) ? mul_prod : mul_pipe[MUL_IDX];

  // Divider model: div_ready after div_dly+1 cycles of div_start.
  int div_cnt;
  always @(posedge clk) begin
    if (rst || !div_start || div_annul) div_cnt <= 0;
    else div_cnt <= div_cnt + 1;
  end
  assign div_ready  = div_start && (div_cnt == div_dly);
  assign div_result = div_ready ? ref_hilo({1'b1, ~div_signed}, div_a, div_b)
                                : 64'hDEAD_BEEF_0BAD_F00D;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare a HI/LO write against the oldest expected value.
  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_spurious_we"}, 64'(hilo_we), 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, 64'(hi_wdata), 64'(e[63:32]));
      chk({tag, "_lo"}, 64'(lo_wdata), 64'(e[31:0]));
    end
  endtask

  // Driver: issue one request (req_valid for one cycle) and observe it.
  // annul_at < 0 means no annul; otherwise annul is raised at that cycle.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_v, input int dly,
                        input int annul_at);
    int exp_done, win, st_cnt, ds_cnt, da_cnt, hw_cnt, hw_cyc;
    logic [1:0] st_after;
    bit fast, is_div, aborted;
    is_div = op[1];
    fast = 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
    fast = is_div && (b == 32'd0);
`endif
    exp_done = !is_div ? MUL_LAT + 1 : (fast ? 1 : dly + 2);
    aborted = (annul_at >= 0);
    win = aborted ? annul_at + 3 : exp_done + 1;
    div_dly = dly;
    if (!aborted) exp_q.push_back(exp_v);
    st_cnt = 0; ds_cnt = 0; da_cnt = 0; hw_cnt = 0; hw_cyc = -1;
    st_after = 2'b11;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    for (int c = 0; c <= win; c++) begin
      annul = aborted && (c == annul_at);
      @(negedge clk);
      if (stallreq) st_cnt++;
      if (div_start) ds_cnt++;
      if (div_annul) da_cnt++;
      if (aborted && c == annul_at + 1) st_after = dbg_state;
      if (hilo_we) begin
        hw_cnt++;
        if (hw_cyc < 0) hw_cyc = c;
        pop_check(tag);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; annul = 1'b0;
      req_a = $urandom; req_b = $urandom;
    end
    if (aborted) begin
      chk_i({tag, "_stall_cycles"}, st_cnt, (annul_at == 0) ? 0 : annul_at + 1);
      chk_i({tag, "_div_start_cycles"}, ds_cnt,
            (is_div && !fast && annul_at > 0) ? annul_at : 0);
      chk_i({tag, "_div_annul_pulses"}, da_cnt,
            (is_div && !fast && annul_at > 0) ? 1 : 0);
      chk_i({tag, "_hilo_we_count"}, hw_cnt, 0);
      chk({tag, "_state_after_annul"}, 64'(st_after), 64'(ST_IDLE));
    end else begin
      chk_i({tag, "_stall_cycles"}, st_cnt, exp_done);
      chk_i({tag, "_div_start_cycles"}, ds_cnt, (is_div && !fast) ? dly + 1 : 0);
      chk_i({tag, "_div_annul_pulses"}, da_cnt, 0);
      chk_i({tag, "_hilo_we_count"}, hw_cnt, 1);
      chk_i({tag, "_hilo_we_cycle"}, hw_cyc, exp_done);
    end
    exp_q.delete();
  endtask

  initial begin
    int seen, cyc1, cyc2, hw_cnt, fast_i;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    int r_dly, r_annul;

    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 32'd0; req_b = 32'd0;
    annul = 1'b0;

    // Reset: a request during reset must not raise stallreq.
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b1;
    @(negedge clk);
    chk("reset_stallreq_with_req", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("reset_stallreq", 64'(stallreq), 64'd0);
    chk("reset_hilo_we", 64'(hilo_we), 64'd0);
    chk("reset_div_start", 64'(div_start), 64'd0);
    chk("reset_div_annul", 64'(div_annul), 64'd0);
    chk("reset_signed", 64'({mul_signed, div_signed}), 64'd0);
    chk("reset_operands", {mul_a, div_b}, 64'd0);
    chk("reset_wdata", {hi_wdata, lo_wdata}, 64'd0);
    @(posedge clk); #1;

    // Directed cases from the test plan.
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0, -1);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 0, -1);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, -1);
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 3, -1);
    run_op("div_annul", OP_DIV, 32'd1000, 32'd3, 64'd0, 33, 10);
    run_op("div_annul_ready", OP_DIV, 32'd1000, 32'd3, 64'd0, 4, 5);
    run_op("idle_annul", OP_MULT, 32'd5, 32'd6, 64'd0, 0, 0);
    run_op("mul_annul", OP_MULTU, 32'd5, 32'd6, 64'd0, 0, 1);

    // Reset in the middle of a divide: acts as annul, no div_annul pulse.
    div_dly = 33;
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd123; req_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_div_annul", 64'(div_annul), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    hw_cnt = 0;
    @(negedge clk);
    chk("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_mid_stallreq", 64'(stallreq), 64'd0);
    chk("rst_mid_operands", {mul_a, mul_b}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (hilo_we) hw_cnt++;
      @(negedge clk);
    end
    chk_i("rst_mid_hilo_we_count", hw_cnt, 0);
    @(posedge clk); #1;

    // Two DIVU back to back with req_valid held through DONE.
    div_dly = 3;
    exp_q.push_back({32'd2, 32'd14});
    exp_q.push_back({32'd2, 32'd8});
    seen = 0; cyc1 = -1; cyc2 = -1;
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cyc1 >= 0 && c == cyc1 + 1) chk("b2b_second_accept_stall", 64'(stallreq), 64'd1);
      if (hilo_we) begin
        seen++;
        if (seen == 1) cyc1 = c;
        else if (seen == 2) cyc2 = c;
        pop_check("b2b");
      end
      @(posedge clk); #1;
      if (seen == 1 && c == cyc1) begin req_a = 32'd50; req_b = 32'd6; end
      if (cyc1 >= 0 && c == cyc1 + 1) req_valid = 1'b0;
    end
    chk_i("b2b_hilo_we_count", seen, 2);
    chk_i("b2b_first_done", cyc1, 5);
    chk_i("b2b_second_done", cyc2, 11);
    exp_q.delete();

    // Randomized operations against the reference arithmetic.
    for (int n = 0; n < 30; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a = $urandom;
      r_b = $urandom;
      if (r_op[1] && $urandom_range(0, 4) == 0) r_b = 32'd0;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 9));
      r_dly = $urandom_range(0, 12);
      fast_i = 0;
`ifdef MULDIV_DIV0_FAST_EN
      fast_i = (r_op[1] && r_b == 32'd0) ? 1 : 0;
`endif
      r_annul = -1;
      if (fast_i == 0 && $urandom_range(0, 5) == 0)
        r_annul = $urandom_range(0, r_op[1] ? r_dly + 1 : MUL_LAT);
      run_op("rand", r_op, r_a, r_b, ref_hilo(r_op, r_a, r_b), r_dly, r_annul);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
